// File: rtl/wdt_config_regfile.sv
// Watchdog configuration register file. Each channel has shadow/active
// FWLEN, SWLEN, SERVICE (INIT, FLSTAT) and RST_LMT registers. A global
// block provides KEY, COMMIT, LOCK and STATUS. Reads have one-cycle latency.
module wdt_config_regfile #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WREN,
    input  logic                RDEN,
    input  logic [AW-1:0]       ABUS,
    input  logic [DW-1:0]       DBUS,
    output logic [DW-1:0]       RDATA,
    output logic                RVALID,
    output logic [NCH*DW-1:0]   FWLEN,
    output logic [NCH*DW-1:0]   SWLEN,
    output logic [NCH*DW-1:0]   RST_LMT,
    output logic [NCH-1:0]      INIT,
    output logic [NCH*3-1:0]    FLSTAT,
    output logic [NCH-1:0]      WDSRVC,
    output logic                LOCKED,
    output logic                ERR
);

    localparam int unsigned CW = AW - 2;
    localparam logic [CW-1:0] CH_GLB = '1;
    localparam logic [1:0] R_FW   = 2'd0;
    localparam logic [1:0] R_SW   = 2'd1;
    localparam logic [1:0] R_SRV  = 2'd2;
    localparam logic [1:0] R_RL   = 2'd3;
    localparam logic [1:0] R_KEY  = 2'd0;
    localparam logic [1:0] R_CMT  = 2'd1;
    localparam logic [1:0] R_LOCK = 2'd2;
    localparam logic [1:0] R_STAT = 2'd3;

    typedef enum logic {
        KEY_IDLE   = 1'b0,
        KEY_GOT_A5 = 1'b1
    } key_st_e;

    logic [DW-1:0] fw_sh_q [NCH];
    logic [DW-1:0] fw_sh_d [NCH];
    logic [DW-1:0] fw_ac_q [NCH];
    logic [DW-1:0] fw_ac_d [NCH];
    logic [DW-1:0] sw_sh_q [NCH];
    logic [DW-1:0] sw_sh_d [NCH];
    logic [DW-1:0] sw_ac_q [NCH];
    logic [DW-1:0] sw_ac_d [NCH];
    logic [DW-1:0] rl_sh_q [NCH];
    logic [DW-1:0] rl_sh_d [NCH];
    logic [DW-1:0] rl_ac_q [NCH];
    logic [DW-1:0] rl_ac_d [NCH];
    logic [2:0]    fl_sh_q [NCH];
    logic [2:0]    fl_sh_d [NCH];
    logic [2:0]    fl_ac_q [NCH];
    logic [2:0]    fl_ac_d [NCH];
    logic [NCH-1:0] init_sh_q, init_sh_d;
    logic [NCH-1:0] init_ac_q, init_ac_d;
    logic [NCH-1:0] srv_q, srv_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    key_st_e        key_q, key_d;

    logic [CW-1:0]  ch;
    logic [1:0]     r;
    logic           in_range, is_glb, key_wr;
    logic           key_unlock, key_seq_err;
    logic           pend;

    assign ch       = ABUS[AW-1:2];
    assign r        = ABUS[1:0];
    assign in_range = (ch < CW'(NCH));
    assign is_glb   = (ch == CH_GLB);
    assign key_wr   = WREN && is_glb && (r == R_KEY);

    // Any shadow register differing from its active copy
    always_comb begin
        pend = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            if ((fw_sh_q[n] != fw_ac_q[n]) || (sw_sh_q[n] != sw_ac_q[n]) ||
                (rl_sh_q[n] != rl_ac_q[n]) || (fl_sh_q[n] != fl_ac_q[n]) ||
                (init_sh_q[n] != init_ac_q[n])) begin
                pend = 1'b1;
            end
        end
    end

    // Unlock key sequence: 0xA5 then 0x5A with no other write in between
    always_comb begin
        key_d       = key_q;
        key_unlock  = 1'b0;
        key_seq_err = 1'b0;
        case (key_q)
            KEY_IDLE: begin
                if (key_wr && (DBUS[7:0] == 8'hA5)) key_d = KEY_GOT_A5;
            end
            KEY_GOT_A5: begin
                if (WREN) begin
                    key_d = KEY_IDLE;
                    if (key_wr && (DBUS[7:0] == 8'h5A)) key_unlock  = 1'b1;
                    else                                key_seq_err = locked_q;
                end
            end
            default: key_d = KEY_IDLE;
        endcase
    end

    // Register writes, commit, lock, error tracking and read mux
    always_comb begin
        logic err_set;
        logic err_clr;
        logic [DW-1:0] rd_val;

        fw_sh_d   = fw_sh_q;
        fw_ac_d   = fw_ac_q;
        sw_sh_d   = sw_sh_q;
        sw_ac_d   = sw_ac_q;
        rl_sh_d   = rl_sh_q;
        rl_ac_d   = rl_ac_q;
        fl_sh_d   = fl_sh_q;
        fl_ac_d   = fl_ac_q;
        init_sh_d = init_sh_q;
        init_ac_d = init_ac_q;
        srv_d     = '0;
        locked_d  = locked_q;
        err_set   = key_seq_err;
        err_clr   = 1'b0;
        rd_val    = '0;

        if ((WREN || RDEN) && !in_range && !is_glb) err_set = 1'b1;

        // Commit copies the pre-edge shadow values
        if (WREN && is_glb && (r == R_CMT) && DBUS[0]) begin
            fw_ac_d   = fw_sh_q;
            sw_ac_d   = sw_sh_q;
            rl_ac_d   = rl_sh_q;
            fl_ac_d   = fl_sh_q;
            init_ac_d = init_sh_q;
        end

        if (WREN && is_glb && (r == R_LOCK) && DBUS[0]) locked_d = 1'b1;
        else if (key_unlock)                             locked_d = 1'b0;

        if (WREN && is_glb && (r == R_STAT) && DBUS[0]) err_clr = 1'b1;

        for (int n = 0; n < NCH; n++) begin
            if (WREN && in_range && (ch == CW'(n))) begin
                case (r)
                    R_FW: begin
                        if (locked_q) err_set = 1'b1;
                        else          fw_sh_d[n] = DBUS;
                    end
                    R_SW: begin
                        if (locked_q) err_set = 1'b1;
                        else          sw_sh_d[n] = DBUS;
                    end
                    R_SRV: begin
                        srv_d[n] = DBUS[3];
                        if (locked_q) begin
                            if (DBUS[4] || (DBUS[2:0] != 3'b000)) err_set = 1'b1;
                        end else begin
                            init_sh_d[n] = DBUS[4];
                            fl_sh_d[n]   = DBUS[2:0];
                        end
                    end
                    default: begin
                        if (locked_q) err_set = 1'b1;
                        else          rl_sh_d[n] = DBUS;
                    end
                endcase
            end
            if (in_range && (ch == CW'(n))) begin
                case (r)
                    R_FW:    rd_val = fw_sh_q[n];
                    R_SW:    rd_val = sw_sh_q[n];
                    R_SRV:   rd_val = DW'({init_sh_q[n], 1'b0, fl_sh_q[n]});
                    default: rd_val = rl_sh_q[n];
                endcase
            end
        end

        if (is_glb && (r == R_STAT)) begin
            rd_val = DW'({key_q == KEY_GOT_A5, locked_q, pend, err_q});
        end

        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;

        rvalid_d = RDEN;
        rdata_d  = RDEN ? rd_val : rdata_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < NCH; n++) begin
                fw_sh_q[n] <= '0;
                fw_ac_q[n] <= '0;
                sw_sh_q[n] <= '0;
                sw_ac_q[n] <= '0;
                rl_sh_q[n] <= '0;
                rl_ac_q[n] <= '0;
                fl_sh_q[n] <= '0;
                fl_ac_q[n] <= '0;
            end
            init_sh_q <= '0;
            init_ac_q <= '0;
            srv_q     <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            key_q     <= KEY_IDLE;
        end else begin
            fw_sh_q   <= fw_sh_d;
            fw_ac_q   <= fw_ac_d;
            sw_sh_q   <= sw_sh_d;
            sw_ac_q   <= sw_ac_d;
            rl_sh_q   <= rl_sh_d;
            rl_ac_q   <= rl_ac_d;
            fl_sh_q   <= fl_sh_d;
            fl_ac_q   <= fl_ac_d;
            init_sh_q <= init_sh_d;
            init_ac_q <= init_ac_d;
            srv_q     <= srv_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            key_q     <= key_d;
        end
    end

    // Pack active registers onto the channel output buses
    always_comb begin
        FWLEN   = '0;
        SWLEN   = '0;
        RST_LMT = '0;
        FLSTAT  = '0;
        for (int n = 0; n < NCH; n++) begin
            FWLEN[n*DW +: DW]   = fw_ac_q[n];
            SWLEN[n*DW +: DW]   = sw_ac_q[n];
            RST_LMT[n*DW +: DW] = rl_ac_q[n];
            FLSTAT[n*3 +: 3]    = fl_ac_q[n];
        end
    end

    assign INIT   = init_ac_q;
    assign WDSRVC = srv_q;
    assign LOCKED = locked_q;
    assign ERR    = err_q;
    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;

endmodule

// File: tb/tb_wdt_config_regfile.sv
// Bench for wdt_config_regfile: vector table plus hand sequences for lock,
// key and reset corner cases; read data checked through an expectation queue.
module tb_wdt_config_regfile;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              WREN;
    logic              RDEN;
    logic [AW-1:0]     ABUS;
    logic [DW-1:0]     DBUS;
    logic [DW-1:0]     RDATA;
    logic              RVALID;
    logic [NCH*DW-1:0] FWLEN;
    logic [NCH*DW-1:0] SWLEN;
    logic [NCH*DW-1:0] RST_LMT;
    logic [NCH-1:0]    INIT;
    logic [NCH*3-1:0]  FLSTAT;
    logic [NCH-1:0]    WDSRVC;
    logic              LOCKED;
    logic              ERR;

    wdt_config_regfile #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .WREN(WREN), .RDEN(RDEN), .ABUS(ABUS), .DBUS(DBUS),
        .RDATA(RDATA), .RVALID(RVALID), .FWLEN(FWLEN), .SWLEN(SWLEN),
        .RST_LMT(RST_LMT), .INIT(INIT), .FLSTAT(FLSTAT), .WDSRVC(WDSRVC),
        .LOCKED(LOCKED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd = '0;

    typedef struct {
        logic       we;
        logic       re;
        logic [4:0] addr;
        logic [7:0] wd;
        logic [7:0] rexp;
        logic       xerr;
        logic       xlk;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle; read expectations go through the queue
    task automatic cyc(input logic we, input logic re, input logic [4:0] a,
                       input logic [7:0] d, input logic [7:0] rexp);
        logic [DW-1:0] e;
        @(negedge CLK);
        WREN = we; RDEN = re; ABUS = a; DBUS = d;
        if (re) exp_q.push_back(rexp);
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("rvalid@%0h", a), 64'(RVALID), 64'(1'b1));
            chk($sformatf("rdata@%0h", a), 64'(RDATA), 64'(e));
            last_rd = e;
        end else begin
            chk("rvalid_idle", 64'(RVALID), 64'(1'b0));
            chk("rdata_hold", 64'(RDATA), 64'(last_rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'h04, 8'h40, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'h04, 8'h00, 8'h40, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h02, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'h1D, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'h0B, 8'h05, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 5'h0B, 8'h11, 8'h05, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'h0B, 8'h00, 8'h11, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 5'h0A, 8'h1F, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 5'h0A, 8'h00, 8'h17, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'h10, 8'h33, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h03, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'h10, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 5'h1F, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h02, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 5'h1D, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 5'h1F, 8'h00, 8'h00, 1'b0, 1'b0};

        RST = 1'b1; WREN = 1'b0; RDEN = 1'b0; ABUS = '0; DBUS = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_fwlen", 64'(FWLEN), 64'(0));
        chk("rst_locked", 64'(LOCKED), 64'(0));
        chk("rst_err", 64'(ERR), 64'(0));
        chk("rst_rvalid", 64'(RVALID), 64'(0));
        chk("rst_rdata", 64'(RDATA), 64'(0));
        @(negedge CLK);
        RST = 1'b0;

        // Unlocked writes, readback, commit, out-of-range, same-cycle rd/wr
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd, tbl[i].rexp);
            chk($sformatf("err_v%0d", i), 64'(ERR), 64'(tbl[i].xerr));
            chk($sformatf("locked_v%0d", i), 64'(LOCKED), 64'(tbl[i].xlk));
            if (i == 1) chk("fwlen_precommit", 64'(FWLEN), 64'(0));
            if (i == 3) chk("fwlen_commit", 64'(FWLEN), 64'(32'h0000_4000));
            if (i == 8) chk("wdsrvc_ch2", 64'(WDSRVC), 64'(4'b0100));
            if (i == 9) chk("wdsrvc_ch2_end", 64'(WDSRVC), 64'(4'b0000));
        end
        chk("rst_lmt_active", 64'(RST_LMT), 64'(32'h0011_0000));
        chk("init_active", 64'(INIT), 64'(4'b0100));
        chk("flstat_active", 64'(FLSTAT), 64'(12'h1C0));

        // Locked: config writes rejected, service pulse still produced
        cyc(1'b1, 1'b0, 5'h1E, 8'h01, 8'h00);
        chk("locked_set", 64'(LOCKED), 64'(1));
        cyc(1'b1, 1'b0, 5'h01, 8'h22, 8'h00);
        chk("err_locked_wr", 64'(ERR), 64'(1));
        cyc(1'b0, 1'b1, 5'h01, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 5'h02, 8'h08, 8'h00);
        chk("wdsrvc_pulse", 64'(WDSRVC), 64'(4'b0001));
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 8'h00);
        chk("wdsrvc_drop", 64'(WDSRVC), 64'(4'b0000));
        cyc(1'b1, 1'b0, 5'h1E, 8'h00, 8'h00);
        chk("lock_wr0", 64'(LOCKED), 64'(1));

        // Key sequence unlock, then an interrupted sequence
        cyc(1'b1, 1'b0, 5'h1F, 8'h01, 8'h00);
        chk("err_clear", 64'(ERR), 64'(0));
        cyc(1'b1, 1'b0, 5'h1C, 8'hA5, 8'h00);
        cyc(1'b0, 1'b1, 5'h1F, 8'h00, 8'h0C);
        cyc(1'b1, 1'b0, 5'h1C, 8'h5A, 8'h00);
        chk("unlocked", 64'(LOCKED), 64'(0));
        chk("unlock_err", 64'(ERR), 64'(0));
        cyc(1'b0, 1'b1, 5'h1F, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 5'h1E, 8'h01, 8'h00);
        cyc(1'b1, 1'b0, 5'h1C, 8'hA5, 8'h00);
        cyc(1'b1, 1'b0, 5'h04, 8'h99, 8'h00);
        cyc(1'b1, 1'b0, 5'h1C, 8'h5A, 8'h00);
        chk("still_locked", 64'(LOCKED), 64'(1));
        chk("seq_err", 64'(ERR), 64'(1));
        cyc(1'b0, 1'b1, 5'h04, 8'h00, 8'h40);
        cyc(1'b0, 1'b1, 5'h1F, 8'h00, 8'h05);

        // Reset in GOT_A5 with a read and a service write in the same cycle
        cyc(1'b1, 1'b0, 5'h1C, 8'hA5, 8'h00);
        cyc(1'b0, 1'b1, 5'h1F, 8'h00, 8'h0D);
        @(negedge CLK);
        RST = 1'b1; WREN = 1'b1; RDEN = 1'b1; ABUS = 5'h02; DBUS = 8'h08;
        @(posedge CLK);
        #1;
        chk("r_fwlen", 64'(FWLEN), 64'(0));
        chk("r_swlen", 64'(SWLEN), 64'(0));
        chk("r_rstlmt", 64'(RST_LMT), 64'(0));
        chk("r_init", 64'(INIT), 64'(0));
        chk("r_flstat", 64'(FLSTAT), 64'(0));
        chk("r_wdsrvc", 64'(WDSRVC), 64'(0));
        chk("r_locked", 64'(LOCKED), 64'(0));
        chk("r_err", 64'(ERR), 64'(0));
        chk("r_rvalid", 64'(RVALID), 64'(0));
        chk("r_rdata", 64'(RDATA), 64'(0));
        last_rd = '0;
        @(negedge CLK);
        RST = 1'b0; WREN = 1'b0; RDEN = 1'b0;
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 8'h00);
        chk("r_wdsrvc_after", 64'(WDSRVC), 64'(0));
        cyc(1'b0, 1'b1, 5'h1F, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 5'h0B, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 5'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
